// File: rtl/irq_pkg.sv
// Shared types and defaults for the external interrupt controller.
package irq_pkg;
  typedef enum logic [1:0] {IDLE, REQ, SERV} irq_state_t;
  localparam int IRQ_NSRC_DEFAULT = 4;
endpackage

// File: rtl/irq_sync.sv
// Two-flop synchroniser per line plus a previous-value flop; edge_o pulses
// for one cycle on each synchronised rising edge.
module irq_sync #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] async_i,
  output logic [W-1:0] edge_o
);
  logic [W-1:0] sync1_q, sync2_q, prev_q;
  logic [W-1:0] sync1_d, sync2_d, prev_d;

  always_comb begin
    sync1_d = async_i;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  // prev_q resets to 0, so a line held high through reset yields one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  assign edge_o = sync2_q & ~prev_q;
endmodule

// File: rtl/ext_irq_ctrl.sv
// External interrupt controller: edge-latched pending bits, lowest-index
// fixed-priority selection and a request/service handshake with the CPU.
module ext_irq_ctrl
  import irq_pkg::*;
#(
  parameter int NSRC = IRQ_NSRC_DEFAULT,
  parameter int IDW  = $clog2(NSRC)
) (
  input  logic            CLOCK_50,
  input  logic            reset,
  input  logic [NSRC-1:0] irq_src,
  input  logic [NSRC-1:0] irq_enable,
  input  logic            ExtlAck,
  input  logic            eoi,
  output logic            ExtIRQ,
  output logic [IDW-1:0]  irq_id,
  output logic [NSRC-1:0] irq_pending,
  output logic            irq_busy
);
  logic [NSRC-1:0] edge_vec;
  logic [NSRC-1:0] pending_q, pending_d;
  logic [NSRC-1:0] cand, clr;
  logic [IDW-1:0]  win;
  irq_state_t      state_q, state_d;
  logic            ext_irq_q, ext_irq_d;
  logic            busy_q, busy_d;
  logic [IDW-1:0]  irq_id_q, irq_id_d;

  irq_sync #(.W(NSRC)) u_sync (
    .clk     (CLOCK_50),
    .rst_n   (reset),
    .async_i (irq_src),
    .edge_o  (edge_vec)
  );

  always_comb begin
    cand = pending_q & irq_enable;
    win  = '0;
    // Scan downwards so the lowest set index is the last one written.
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (cand[i]) win = IDW'(i);
    end
  end

  always_comb begin
    state_d   = state_q;
    ext_irq_d = ext_irq_q;
    busy_d    = busy_q;
    irq_id_d  = irq_id_q;
    clr       = '0;
    case (state_q)
      IDLE: begin
        if (|cand) begin
          state_d   = REQ;
          irq_id_d  = win;
          ext_irq_d = 1'b1;
          busy_d    = 1'b1;
        end
      end
      REQ: begin
        // irq_id stays frozen here; an eoi arriving with the ack is ignored.
        if (ExtlAck) begin
          for (int i = 0; i < NSRC; i++) begin
            clr[i] = (irq_id_q == IDW'(i));
          end
          state_d   = SERV;
          ext_irq_d = 1'b0;
        end
      end
      SERV: begin
        if (eoi) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d   = IDLE;
        ext_irq_d = 1'b0;
        busy_d    = 1'b0;
      end
    endcase
    // A fresh edge on the cleared source wins, so it is served again later.
    pending_d = (pending_q & ~clr) | edge_vec;
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      ext_irq_q <= 1'b0;
      busy_q    <= 1'b0;
      irq_id_q  <= '0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      ext_irq_q <= ext_irq_d;
      busy_q    <= busy_d;
      irq_id_q  <= irq_id_d;
      pending_q <= pending_d;
    end
  end

  assign ExtIRQ      = ext_irq_q;
  assign irq_busy    = busy_q;
  assign irq_id      = irq_id_q;
  assign irq_pending = pending_q;
endmodule

// File: tb/tb_ext_irq_ctrl.sv
// Self-checking bench for ext_irq_ctrl: directed scenarios plus random traffic
// against a sample-history reference model.
module tb_ext_irq_ctrl;
  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] irq_src = '0;
  logic [3:0] irq_enable = '0;
  logic       ExtlAck = 1'b0;
  logic       eoi = 1'b0;
  logic       ExtIRQ;
  logic [1:0] irq_id;
  logic [3:0] irq_pending;
  logic       irq_busy;

  int checks = 0;
  int fails = 0;

  ext_irq_ctrl #(.NSRC(4)) dut (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .irq_src     (irq_src),
    .irq_enable  (irq_enable),
    .ExtlAck     (ExtlAck),
    .eoi         (eoi),
    .ExtIRQ      (ExtIRQ),
    .irq_id      (irq_id),
    .irq_pending (irq_pending),
    .irq_busy    (irq_busy)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  // Reference model: edges come from the history of sampled lines
  // (sampled high two edges ago, low three edges ago).
  logic [3:0] hist[$];
  int         m_phase = 0;  // 0 idle, 1 requesting, 2 in service
  logic [1:0] m_id = '0;
  logic [3:0] m_pend = '0;

  always @(posedge CLOCK_50 or negedge reset) begin : model
    logic [3:0] s2, s3, e, cand, clr;
    if (!reset) begin
      hist.delete();
      m_phase = 0;
      m_id    = '0;
      m_pend  = '0;
    end else begin
      hist.push_back(irq_src);
      s2 = (hist.size() >= 3) ? hist[hist.size()-3] : 4'b0;
      s3 = (hist.size() >= 4) ? hist[hist.size()-4] : 4'b0;
      if (hist.size() > 8) void'(hist.pop_front());
      e    = s2 & ~s3;
      clr  = '0;
      cand = m_pend & irq_enable;
      if (m_phase == 1) begin
        if (ExtlAck) begin
          clr[m_id] = 1'b1;
          m_phase   = 2;
        end
      end else if (m_phase == 2) begin
        if (eoi) m_phase = 0;
      end else if (cand != 0) begin
        for (int i = 3; i >= 0; i--) if (cand[i]) m_id = 2'(i);
        m_phase = 1;
      end
      m_pend = (m_pend & ~clr) | e;
    end
  end

  wire [7:0] dut_v = {ExtIRQ, irq_busy, irq_id, irq_pending};
  wire [7:0] exp_v = {m_phase == 1, m_phase != 0, m_id, m_pend};

  task automatic tick();
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) tick();
    checks++;
    if (dut_v !== 8'h00) begin
      fails++;
      $display("FAIL reset_state: got %h required 00", dut_v);
    end
    reset = 1'b1;
    irq_enable = 4'hF;
    tick();
    checks++;
    if (dut_v !== exp_v) begin
      fails++;
      $display("FAIL reset_release: got %h required %h", dut_v, exp_v);
    end
  endtask

  task automatic test_basic();
    irq_src = 4'b0100;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (c == 1) irq_src = 4'b0000;
      checks++;
      if (dut_v !== exp_v) begin
        fails++;
        $display("FAIL basic_cycle%0d: got %h required %h", c, dut_v, exp_v);
      end
      if (c == 2) begin
        checks++;
        if (irq_pending !== 4'b0100 || ExtIRQ !== 1'b0) begin
          fails++;
          $display("FAIL basic_pend: got pend=%b irq=%b required 0100/0", irq_pending, ExtIRQ);
        end
      end
    end
    checks++;
    if (ExtIRQ !== 1'b1 || irq_id !== 2'd2) begin
      fails++;
      $display("FAIL basic_req: got irq=%b id=%0d required 1/2", ExtIRQ, irq_id);
    end
    ExtlAck = 1'b1;
    tick();
    ExtlAck = 1'b0;
    checks++;
    if (ExtIRQ !== 1'b0 || irq_pending !== 4'b0000 || irq_busy !== 1'b1) begin
      fails++;
      $display("FAIL basic_ack: got irq=%b pend=%b busy=%b required 0/0000/1", ExtIRQ, irq_pending, irq_busy);
    end
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
    checks++;
    if (irq_busy !== 1'b0 || dut_v !== exp_v) begin
      fails++;
      $display("FAIL basic_eoi: got %h required %h busy 0", dut_v, exp_v);
    end
    $display("basic: source 2 serviced");
  endtask

  task automatic test_same_cycle();
    irq_src = 4'b1010;
    repeat (2) tick();
    irq_src = 4'b0000;
    repeat (2) tick();
    checks++;
    if (ExtIRQ !== 1'b1 || irq_id !== 2'd1) begin
      fails++;
      $display("FAIL prio_first: got irq=%b id=%0d required 1/1", ExtIRQ, irq_id);
    end
    ExtlAck = 1'b1;
    tick();
    ExtlAck = 1'b0;
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
    checks++;
    if (ExtIRQ !== 1'b0 || irq_busy !== 1'b0) begin
      fails++;
      $display("FAIL prio_gap: got irq=%b busy=%b required 0/0", ExtIRQ, irq_busy);
    end
    tick();
    checks++;
    if (ExtIRQ !== 1'b1 || irq_id !== 2'd3 || dut_v !== exp_v) begin
      fails++;
      $display("FAIL prio_second: got %h required %h id 3", dut_v, exp_v);
    end
    ExtlAck = 1'b1;
    tick();
    ExtlAck = 1'b0;
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
    $display("same_cycle: sources 1 then 3 serviced");
  endtask

  task automatic test_no_preempt();
    irq_src = 4'b0100;
    repeat (2) tick();
    irq_src = 4'b0000;
    repeat (2) tick();
    irq_src = 4'b0001;
    repeat (2) tick();
    irq_src = 4'b0000;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (irq_id !== 2'd2 || ExtIRQ !== 1'b1 || dut_v !== exp_v) begin
        fails++;
        $display("FAIL nopreempt_hold%0d: got %h required %h id 2", c, dut_v, exp_v);
      end
    end
    ExtlAck = 1'b1;
    tick();
    ExtlAck = 1'b0;
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
    tick();
    checks++;
    if (ExtIRQ !== 1'b1 || irq_id !== 2'd0) begin
      fails++;
      $display("FAIL nopreempt_next: got irq=%b id=%0d required 1/0", ExtIRQ, irq_id);
    end
    ExtlAck = 1'b1;
    tick();
    ExtlAck = 1'b0;
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
    $display("no_preempt: sources 2 then 0 serviced");
  endtask

  task automatic test_masked();
    irq_enable = 4'b1101;
    irq_src = 4'b0010;
    repeat (2) tick();
    irq_src = 4'b0000;
    repeat (3) tick();
    checks++;
    if (irq_pending !== 4'b0010 || ExtIRQ !== 1'b0 || dut_v !== exp_v) begin
      fails++;
      $display("FAIL masked_hold: got %h required %h", dut_v, exp_v);
    end
    irq_enable = 4'hF;
    tick();
    checks++;
    if (ExtIRQ !== 1'b1 || irq_id !== 2'd1) begin
      fails++;
      $display("FAIL masked_enable: got irq=%b id=%0d required 1/1", ExtIRQ, irq_id);
    end
    ExtlAck = 1'b1;
    tick();
    ExtlAck = 1'b0;
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
    $display("masked: source 1 serviced after enable");
  endtask

  task automatic test_back_to_back();
    irq_src = 4'b0100;
    repeat (2) tick();
    irq_src = 4'b0000;
    repeat (2) tick();
    // New edge timed to reach the pending register on the ack edge.
    irq_src = 4'b0100;
    tick();
    irq_src = 4'b0000;
    tick();
    ExtlAck = 1'b1;
    tick();
    ExtlAck = 1'b0;
    checks++;
    if (irq_pending[2] !== 1'b1 || ExtIRQ !== 1'b0 || dut_v !== exp_v) begin
      fails++;
      $display("FAIL repend_ack: got %h required %h pend[2]=1", dut_v, exp_v);
    end
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
    tick();
    checks++;
    if (ExtIRQ !== 1'b1 || irq_id !== 2'd2) begin
      fails++;
      $display("FAIL repend_rereq: got irq=%b id=%0d required 1/2", ExtIRQ, irq_id);
    end
    ExtlAck = 1'b1;
    tick();
    ExtlAck = 1'b0;
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
    $display("back_to_back: source 2 serviced twice");
  endtask

  task automatic test_reset_mid();
    irq_src = 4'b0001;
    repeat (4) tick();
    checks++;
    if (ExtIRQ !== 1'b1) begin
      fails++;
      $display("FAIL rstmid_req: got irq=%b required 1", ExtIRQ);
    end
    #3 reset = 1'b0;
    #1;
    checks++;
    if (dut_v !== 8'h00) begin
      fails++;
      $display("FAIL rstmid_async: got %h required 00", dut_v);
    end
    @(negedge CLOCK_50);
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (ExtIRQ !== (c == 3) || dut_v !== exp_v) begin
        fails++;
        $display("FAIL rstmid_cycle%0d: got %h required %h", c, dut_v, exp_v);
      end
    end
    checks++;
    if (irq_id !== 2'd0) begin
      fails++;
      $display("FAIL rstmid_id: got %0d required 0", irq_id);
    end
    ExtlAck = 1'b1;
    tick();
    ExtlAck = 1'b0;
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++;
      if (ExtIRQ !== 1'b0 || irq_pending !== 4'b0000) begin
        fails++;
        $display("FAIL rstmid_single%0d: got irq=%b pend=%b required 0/0000", c, ExtIRQ, irq_pending);
      end
    end
    irq_src = 4'b0000;
    $display("reset_mid: source 0 requested once after reset");
  endtask

  task automatic test_random();
    int acks = 0;
    for (int c = 0; c < 400; c++) begin
      irq_src = irq_src ^ (4'($urandom) & 4'($urandom) & 4'($urandom));
      if ($urandom_range(0, 7) == 0) irq_enable = 4'($urandom);
      ExtlAck = ($urandom_range(0, 2) == 0);
      eoi = ($urandom_range(0, 2) == 0);
      if (ExtIRQ && ExtlAck) acks++;
      tick();
      checks++;
      if (dut_v !== exp_v) begin
        fails++;
        $display("FAIL random_cycle%0d: got %h required %h", c, dut_v, exp_v);
      end
    end
    irq_src = '0;
    irq_enable = 4'hF;
    ExtlAck = 1'b1;
    eoi = 1'b1;
    for (int c = 0; c < 60; c++) begin
      tick();
      checks++;
      if (dut_v !== exp_v) begin
        fails++;
        $display("FAIL drain_cycle%0d: got %h required %h", c, dut_v, exp_v);
      end
    end
    ExtlAck = 1'b0;
    eoi = 1'b0;
    checks++;
    if ({ExtIRQ, irq_busy, irq_pending} !== 6'b0) begin
      fails++;
      $display("FAIL drain_idle: got irq=%b busy=%b pend=%b required all 0", ExtIRQ, irq_busy, irq_pending);
    end
    $display("random: %0d acknowledged requests", acks);
  endtask

  initial begin
    @(negedge CLOCK_50);
    test_reset();
    test_basic();
    test_same_cycle();
    test_no_preempt();
    test_masked();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/ext_irq_ctrl.md
# ext_irq_ctrl

External interrupt controller sitting directly upstream of the processor top level: it collects asynchronous interrupt lines from peripherals, synchronises and edge-detects them, and holds them as pending requests. It drives the processor's `ExtIRQ` input and consumes its `ExtlAck` acknowledge. A fixed-priority arbiter picks one request at a time and reports its index as the exception cause. The processor ends each service with an end-of-interrupt strobe.

## Interface
Parameters:
- `NSRC`, 4: number of interrupt sources, 2..16.
- `IDW`, `$clog2(NSRC)`: width of the source index.

Ports:
- `CLOCK_50`, in, 1: single clock; all flops on its rising edge.
- `reset`, in, 1: asynchronous, active-low. Low clears all state immediately.
- `irq_src`, in, NSRC: raw asynchronous interrupt lines, rising-edge triggered.
- `irq_enable`, in, NSRC: per-source mask, synchronous to `CLOCK_50`; 1 = may be selected.
- `ExtlAck`, in, 1: processor acknowledge of `ExtIRQ`.
- `eoi`, in, 1: end-of-interrupt strobe (processor `ERet`), one cycle.
- `ExtIRQ`, out, 1: registered interrupt request to the processor.
- `irq_id`, out, IDW: index of the source being requested or serviced.
- `irq_pending`, out, NSRC: registered pending vector, for status readout.
- `irq_busy`, out, 1: high in REQ and SERV.

## Operation
- Per source, a 2-flop synchroniser feeds a previous-value flop.
- `edge[i]` = sync2[i] & ~prev[i].
- All three flops reset to 0. A line held high through reset release therefore produces exactly one edge.
- Pending update each cycle: `pending_next[i] = (pending[i] & ~clr[i]) | edge[i]`. Set wins over clear on the same cycle.
- Candidate set is `pending & irq_enable`. Selection is fixed priority: lowest index wins.
- Masked pending bits are kept. They become eligible as soon as `irq_enable` rises.
- FSM states `IDLE`, `REQ`, `SERV`:
  - `IDLE`: if the candidate set is non-zero, latch the winner into `irq_id` and go to `REQ`.
  - `REQ`: `ExtIRQ`=1. `irq_id` is frozen, with no preemption and no reselection even if a higher-priority source arrives or the winner's enable drops.
    - On `ExtlAck`=1: `clr[irq_id]`=1 and go to `SERV`.
  - `SERV`: `ExtIRQ`=0 and `irq_id` is held. On `eoi`=1, go to `IDLE`.
- `ExtlAck` outside `REQ` and `eoi` outside `SERV` are ignored.
- `ExtlAck` and `eoi` both high in `REQ`: only the ack is acted on, and the next state is `SERV`.
- A new edge on the serviced source during `SERV` re-pends it. It is requested again after `eoi`.

## Timing
- Reset values: `ExtIRQ`=0, `irq_id`=0, `irq_pending`=0, `irq_busy`=0, state `IDLE`, all synchroniser flops 0.
- Latency, with cycle 0 being the first rising edge at which `irq_src[i]` is sampled high (controller idle, source enabled):
  - cycle 2: pending bit set.
  - cycle 3: `ExtIRQ`=1 and `irq_id` valid.
- Ack handling, with `ExtlAck` sampled high at edge t while in `REQ`:
  - edge t: `ExtIRQ`=0, pending bit cleared, `irq_busy` stays 1.
- End of service, with `eoi` sampled at edge u while in `SERV`:
  - edge u: `IDLE`, `irq_busy`=0.
  - edge u+1: earliest next `ExtIRQ`=1 if anything is pending.
- Minimum detectable pulse: 1 clock high and 1 clock low, sampled. Shorter pulses may be lost.
- Reset asserted mid-operation: outputs go to reset values asynchronously, with no wait for an edge. Pending requests are discarded.

## Structure
- Package `irq_pkg`:
  - `typedef enum logic [1:0] {IDLE, REQ, SERV} irq_state_t`
  - localparam `IRQ_NSRC_DEFAULT = 4`
- Sub-module `irq_sync` (parameter `W`): 2-flop synchroniser plus previous-value flop with edge output, instantiated once with `W=NSRC`.
- Top `ext_irq_ctrl`: pending register, priority encoder, FSM, output registers.

## Test plan
- Source 2 pulsed high for 2 cycles, all enabled → `irq_pending`=4'b0100 at cycle 2, `ExtIRQ`=1 with `irq_id`=2 at cycle 3. Ack → `ExtIRQ`=0 next edge and pending=0. `eoi` → `irq_busy`=0.
- Sources 3 and 1 rise on the same cycle → `irq_id`=1 served first. After `eoi`, `irq_id`=3 requested at the next edge, with no stray request in between.
- Source 0 edge while `REQ` is active for source 2 → `irq_id` stays 2 until ack. Source 0 is requested right after the `eoi` of source 2.
- Source 1 edge with `irq_enable`=0 → pending=4'b0010, `ExtIRQ` stays 0. Set enable[1]=1 → `ExtIRQ`=1 with `irq_id`=1 one cycle later.
- Source 2 re-edges in the same cycle its ack clears it → pending bit remains 1, and the source is re-requested after `eoi`.
- `irq_src[0]` held high, `reset` low mid-`REQ` → `ExtIRQ`=0 with no clock edge. After release, one request with `irq_id`=0 appears at cycle 3 and no second one appears.
